// File: rtl/carry_resolve_pipe.sv
// carry_resolve_pipe: two-stage carry-propagate adder that resolves the
// carry-save sum/carry vectors from a multiplier reduction tree into a single
// binary result. The add is split at bit L: stage 1 adds the low half, and
// stage 2 adds the high half plus the low-half carry. Each stage has
// valid/ready handshaking and can stall independently.
module carry_resolve_pipe #(
  parameter int unsigned PARM_MANT = 23
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [2*PARM_MANT+2:0]   sum_i,
  input  logic [2*PARM_MANT+2:0]   carry_i,
  input  logic                     supp_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [2*PARM_MANT+2:0]   result_o,
  output logic                     ovf_o
);

  localparam int unsigned W = 2 * PARM_MANT + 3;
  localparam int unsigned L = (W + 1) / 2;
  localparam int unsigned H = W - L;

  // stage 1 registers
  logic         r_s1_valid;
  logic [L-1:0] r_s1_lo;
  logic         r_s1_c1;
  logic [H-1:0] r_s1_sum_hi;
  logic [H-1:0] r_s1_carry_hi;
  logic         r_s1_supp;

  // stage 2 registers
  logic         r_s2_valid;
  logic [W-1:0] r_s2_result;
  logic         r_s2_ovf;

  // datapath and handshake wires
  logic [L:0]   w_lo_sum;
  logic [H:0]   w_hi_sum;
  logic         w_s1_load;
  logic         w_s2_load;

  // Stage 1 can always take a new pair when its contents are free to advance
  // into stage 2 in the same cycle.
  assign ready_o   = ~r_s1_valid | ~r_s2_valid | ready_i;
  assign w_s1_load = valid_i & ready_o;
  assign w_s2_load = r_s1_valid & (~r_s2_valid | ready_i);

  // Low-half add on the inputs and high-half add with the registered split carry
  always_comb begin
    w_lo_sum = {1'b0, sum_i[L-1:0]} + {1'b0, carry_i[L-1:0]};
    w_hi_sum = {1'b0, r_s1_sum_hi} + {1'b0, r_s1_carry_hi} + {{H{1'b0}}, r_s1_c1};
  end

  // Stage 1: capture low-half result, split carry and raw high halves
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid    <= 1'b0;
      r_s1_lo       <= '0;
      r_s1_c1       <= 1'b0;
      r_s1_sum_hi   <= '0;
      r_s1_carry_hi <= '0;
      r_s1_supp     <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid    <= 1'b1;
      r_s1_lo       <= w_lo_sum[L-1:0];
      r_s1_c1       <= w_lo_sum[L];
      r_s1_sum_hi   <= sum_i[W-1:L];
      r_s1_carry_hi <= carry_i[W-1:L];
      r_s1_supp     <= supp_i;
    end else if (w_s2_load) begin
      r_s1_valid    <= 1'b0;
    end
  end

  // Stage 2: assemble the full result and the masked carry-out
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_ovf    <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid  <= 1'b1;
      r_s2_result <= {w_hi_sum[H-1:0], r_s1_lo};
      r_s2_ovf    <= w_hi_sum[H] & ~r_s1_supp;
    end else if (ready_i) begin
      r_s2_valid  <= 1'b0;
    end
  end

  assign valid_o  = r_s2_valid;
  assign result_o = r_s2_result;
  assign ovf_o    = r_s2_ovf;

endmodule

// File: tb/tb_carry_resolve_pipe.sv
// tb_carry_resolve_pipe: directed-vector bench for carry_resolve_pipe at the
// default mantissa width (W = 49, split at bit 25).
module tb_carry_resolve_pipe;

  localparam int unsigned W = 49;

  logic         clk_i;
  logic         rst_ni;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] sum_i;
  logic [W-1:0] carry_i;
  logic         supp_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] result_o;
  logic         ovf_o;

  int unsigned n_vec;
  int unsigned n_err;

  carry_resolve_pipe #(.PARM_MANT(23)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .sum_i    (sum_i),
    .carry_i  (carry_i),
    .supp_i   (supp_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .ovf_o    (ovf_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One isolated pair with ready_i high: empty after one edge, result after two.
  task automatic send_one(input string tag, input logic [W-1:0] s, input logic [W-1:0] c,
                          input logic sp, input logic [W-1:0] exp_res, input logic exp_ovf);
    valid_i = 1'b1; sum_i = s; carry_i = c; supp_i = sp; ready_i = 1'b1;
    tick();
    valid_i = 1'b0; sum_i = '0; carry_i = '0; supp_i = 1'b0;
    chk({tag, "_v1"}, {63'd0, valid_o}, 64'd0);
    tick();
    chk({tag, "_v2"}, {63'd0, valid_o}, 64'd1);
    chk({tag, "_res"}, {15'd0, result_o}, {15'd0, exp_res});
    chk({tag, "_ovf"}, {63'd0, ovf_o}, {63'd0, exp_ovf});
    tick();
    chk({tag, "_drain"}, {63'd0, valid_o}, 64'd0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_ni = 1'b1; valid_i = 1'b0; sum_i = '0; carry_i = '0; supp_i = 1'b0; ready_i = 1'b1;
    #2 rst_ni = 1'b0;
    tick(); tick();
    chk("rst_valid", {63'd0, valid_o}, 64'd0);
    chk("rst_result", {15'd0, result_o}, 64'd0);
    chk("rst_ovf", {63'd0, ovf_o}, 64'd0);
    chk("rst_ready", {63'd0, ready_o}, 64'd1);
    rst_ni = 1'b1;
    tick();

    // basic and carry-boundary vectors
    send_one("one_plus_one", 49'd1, 49'd1, 1'b0, 49'd2, 1'b0);
    send_one("cross_split", 49'h1FFFFFF, 49'd1, 1'b0, 49'h2000000, 1'b0);
    send_one("wrap_ovf", 49'h1FFFFFFFFFFFF, 49'd1, 1'b0, 49'd0, 1'b1);
    send_one("wrap_supp", 49'h1FFFFFFFFFFFF, 49'd1, 1'b1, 49'd0, 1'b0);
    send_one("top_bits", 49'h1000000000000, 49'h1000000000000, 1'b0, 49'd0, 1'b1);
    send_one("mixed", 49'h0ABCDEF123456, 49'h0111111111111, 1'b0, 49'h0BCDF00234567, 1'b0);

    // backpressure: two accepted, third blocked, output held
    ready_i = 1'b0;
    valid_i = 1'b1; sum_i = 49'd1; carry_i = 49'd1;
    chk("bp_rdy1", {63'd0, ready_o}, 64'd1);
    tick();
    sum_i = 49'd2; carry_i = 49'd2;
    chk("bp_rdy2", {63'd0, ready_o}, 64'd1);
    tick();
    sum_i = 49'd3; carry_i = 49'd3;
    chk("bp_rdy3", {63'd0, ready_o}, 64'd0);
    chk("bp_valid", {63'd0, valid_o}, 64'd1);
    chk("bp_hold1", {15'd0, result_o}, 64'd2);
    tick();
    chk("bp_rdy3b", {63'd0, ready_o}, 64'd0);
    chk("bp_hold2", {15'd0, result_o}, 64'd2);
    tick();
    chk("bp_hold3", {15'd0, result_o}, 64'd2);
    ready_i = 1'b1;
    #1;
    chk("bp_release_rdy", {63'd0, ready_o}, 64'd1);
    tick();
    valid_i = 1'b0; sum_i = '0; carry_i = '0;
    chk("bp_out4_v", {63'd0, valid_o}, 64'd1);
    chk("bp_out4", {15'd0, result_o}, 64'd4);
    tick();
    chk("bp_out6_v", {63'd0, valid_o}, 64'd1);
    chk("bp_out6", {15'd0, result_o}, 64'd6);
    tick();
    chk("bp_empty", {63'd0, valid_o}, 64'd0);

    // full throughput: pairs k+k for k = 1..10, back to back
    ready_i = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if (c < 10) begin
        valid_i = 1'b1; sum_i = 49'(c + 1); carry_i = 49'(c + 1);
        chk("tp_ready", {63'd0, ready_o}, 64'd1);
      end else begin
        valid_i = 1'b0; sum_i = '0; carry_i = '0;
      end
      tick();
      if (c >= 1 && c <= 10) begin
        chk("tp_valid", {63'd0, valid_o}, 64'd1);
        chk("tp_result", {15'd0, result_o}, 64'(2 * c));
      end else begin
        chk("tp_idle", {63'd0, valid_o}, 64'd0);
      end
    end

    // reset with two pairs in flight
    valid_i = 1'b1; sum_i = 49'd5; carry_i = 49'd5;
    tick();
    sum_i = 49'd6; carry_i = 49'd6;
    tick();
    valid_i = 1'b0; sum_i = '0; carry_i = '0;
    chk("mr_pre_valid", {63'd0, valid_o}, 64'd1);
    chk("mr_pre_res", {15'd0, result_o}, 64'd10);
    #2 rst_ni = 1'b0;
    #1;
    chk("mr_valid", {63'd0, valid_o}, 64'd0);
    chk("mr_result", {15'd0, result_o}, 64'd0);
    chk("mr_ready", {63'd0, ready_o}, 64'd1);
    tick();
    rst_ni = 1'b1;
    #1;
    chk("mr_rel_ready", {63'd0, ready_o}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_no_ghost", {63'd0, valid_o}, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/carry_resolve_pipe.md
CARRY_RESOLVE_PIPE -- requirements
Module: carry_resolve_pipe

Interface
REQ-001 Parameter: PARM_MANT, default 23, mantissa width; internal width W = 2*PARM_MANT + 3 (49 at default), split point L = (W+1)/2 (25), high part H = W - L (24).
REQ-002 clk_i  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 valid_i  input  1  upstream operand pair valid.
REQ-005 ready_o  output  1  block can accept an operand pair this cycle.
REQ-006 sum_i  input  W  carry-save sum vector from the partial-product reduction tree.
REQ-007 carry_i  input  W  carry-save carry vector, already aligned (pre-shifted) by the tree.
REQ-008 supp_i  input  1  sign-extension suppression flag from the tree, travels with its operand pair.
REQ-009 valid_o  output  1  result valid.
REQ-010 ready_i  input  1  downstream accepts result.
REQ-011 result_o  output  W  (sum_i + carry_i) mod 2^W.
REQ-012 ovf_o  output  1  carry-out of bit W-1, masked by supp.

Function
REQ-013 Transfer in SHALL occur when valid_i && ready_o; transfer out when valid_o && ready_i.
REQ-014 Stage 1 SHALL compute {c1, lo} = sum_i[L-1:0] + carry_i[L-1:0] and register lo, c1, sum_i[W-1:L], carry_i[W-1:L], supp_i, and s1_valid.
REQ-015 Stage 2 SHALL compute {c2, hi} = s1_sum_hi + s1_carry_hi + c1 and register result = {hi, lo}, ovf = c2 & ~s1_supp, and s2_valid.
REQ-016 result_o, ovf_o, and valid_o SHALL be driven directly from stage-2 registers; no combinational path from sum_i/carry_i to outputs.
REQ-017 Latency: a pair accepted at edge N SHALL appear on valid_o/result_o after edge N+2 when ready_i is held 1.
REQ-018 Throughput: with ready_i held 1, one pair SHALL be accepted every cycle.
REQ-019 Stage 2 SHALL load when s1_valid && (~s2_valid || ready_i); s2_valid SHALL clear when the output transfers and stage 1 holds nothing to move.
REQ-020 Stage 1 SHALL load when valid_i && ready_o; s1_valid SHALL clear when its contents move to stage 2 and no new pair is accepted.
REQ-021 ready_o = ~s1_valid || (~s2_valid || ready_i); combinational from ready_i is permitted.
REQ-022 While valid_o && ~ready_i, result_o and ovf_o SHALL be held stable.
REQ-023 At most 2 pairs SHALL be in flight; order SHALL be preserved; no pair SHALL be dropped or duplicated.
REQ-024 Simultaneous output transfer and stage-1 advance in one cycle SHALL replace stage-2 contents without a bubble.
REQ-025 Carry c1 SHALL propagate across the split in all cases, including lo wrap (low-half all ones plus 1).
REQ-026 Bits beyond W SHALL be discarded; ovf_o reports only bit W of the full sum when supp is 0.

Reset
REQ-027 While rst_ni = 0: s1_valid = s2_valid = 0, all data registers = 0, valid_o = 0, result_o = 0, ovf_o = 0.
REQ-028 Assertion mid-operation SHALL discard all in-flight pairs immediately; ready_o SHALL be 1 on the first cycle after release.

Verification
REQ-029 sum_i = 1, carry_i = 1, supp_i = 0, ready_i = 1 -> two cycles later valid_o = 1, result_o = 2, ovf_o = 0.
REQ-030 sum_i = 0x1FFFFFF, carry_i = 1 -> result_o = 0x2000000, which tests the cross-split carry.
REQ-031 sum_i = 2^49-1, carry_i = 1, supp_i = 0 -> result_o = 0, ovf_o = 1; same operands with supp_i = 1 -> result_o = 0, ovf_o = 0.
REQ-032 Backpressure: ready_i = 0, three back-to-back pairs (1+1, 2+2, 3+3) -> first two accepted, ready_o = 0 for the third; result_o held at 2; releasing ready_i yields 2, 4, 6 in order with no loss.
REQ-033 Full throughput: 10 consecutive pairs k+k with ready_i = 1 -> 10 consecutive valid_o cycles with results 2k, beginning two cycles after the first accept.
REQ-034 Reset mid-flight: two pairs in flight, rst_ni pulsed low -> valid_o = 0 and result_o = 0 immediately; neither pair appears after release.
